// File: rtl/lfm_chirp_scheduler_pkg.sv
// Shared types for the LFM chirp scheduler:
// FSM states, profile record and datapath widths.
package lfm_pkg;

    localparam int FREQ_W = 32;
    localparam int LEN_W  = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT,
        GAP,
        FINISH
    } state_t;

    typedef struct packed {
        logic [FREQ_W-1:0] f_start;
        logic [FREQ_W-1:0] f_stop;
        logic [LEN_W-1:0]  chirp_len;
    } profile_t;

endpackage

// File: rtl/lfm_chirp_scheduler_if.sv
// DDS-side bundle: chirp parameters and start out,
// busy/done back from the generator.
interface lfm_chirp_scheduler_if;
    import lfm_pkg::*;

    logic              dds_start;
    logic [FREQ_W-1:0] dds_f_start;
    logic [FREQ_W-1:0] dds_f_stop;
    logic [FREQ_W-1:0] dds_f_clk;
    logic [LEN_W-1:0]  dds_chirp_len;
    logic              dds_busy;
    logic              dds_done;

    modport master (
        output dds_start, dds_f_start, dds_f_stop,
        output dds_f_clk, dds_chirp_len,
        input  dds_busy, dds_done
    );

    modport slave (
        input  dds_start, dds_f_start, dds_f_stop,
        input  dds_f_clk, dds_chirp_len,
        output dds_busy, dds_done
    );

endinterface

// File: rtl/lfm_chirp_scheduler_profile_ram.sv
// Profile table: one synchronous write port,
// one combinational read port, cleared by reset.
module lfm_profile_ram
    import lfm_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int PROF_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [PROF_BITS-1:0] waddr,
    input  profile_t             wdata,
    input  logic [PROF_BITS-1:0] raddr,
    output profile_t             rdata
);

    profile_t mem [NUM_PROFILES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lfm_chirp_scheduler.sv
// Burst sequencer for the LFM DDS: plays table profiles
// at a fixed PRI and flags overrun / missing done.
module lfm_chirp_scheduler
    import lfm_pkg::*;
#(
    parameter int NUM_PROFILES   = 4,
    parameter int PROF_BITS      = 2,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_MARGIN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [PROF_BITS-1:0] cfg_addr,
    input  logic [FREQ_W-1:0]    cfg_f_start,
    input  logic [FREQ_W-1:0]    cfg_f_stop,
    input  logic [LEN_W-1:0]     cfg_chirp_len,
    input  logic [FREQ_W-1:0]    f_clk,
    input  logic [PROF_BITS:0]   n_profiles,
    input  logic [CNT_W-1:0]     pri,
    input  logic [CNT_W-1:0]     burst_len,
    input  logic                 arm,
    input  logic                 stop,
    lfm_chirp_scheduler_if.master dds,
    output logic                 busy,
    output logic                 burst_done,
    output logic [PROF_BITS-1:0] profile_idx,
    output logic [CNT_W-1:0]     chirp_cnt,
    output logic                 overrun,
    output logic                 timeout_err
);

    state_t            state, state_nxt;
    profile_t          prof_rd, prof_wr;
    logic [FREQ_W-1:0] f_start_q, f_stop_q, f_clk_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  pri_cnt, tmo_cnt, pri_thr;
    logic [LEN_W:0]    tmo_limit, tmo_next;
    logic [PROF_BITS:0] n_eff;
    logic [PROF_BITS-1:0] last_idx;
    logic              stop_req, stop_hit;
    logic              pri_due, tmo_reach, burst_full;
    logic              clr, load, start, advance;
    logic              set_ovr, set_tmo;

    assign prof_wr = '{cfg_f_start, cfg_f_stop, cfg_chirp_len};

    lfm_profile_ram #(
        .NUM_PROFILES (NUM_PROFILES),
        .PROF_BITS    (PROF_BITS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (prof_wr),
        .raddr (profile_idx),
        .rdata (prof_rd)
    );

    always_comb begin
        n_eff = n_profiles;
        if (n_eff == '0) begin
            n_eff = (PROF_BITS+1)'(1);
        end
        if (n_eff > (PROF_BITS+1)'(NUM_PROFILES)) begin
            n_eff = (PROF_BITS+1)'(NUM_PROFILES);
        end
        last_idx = PROF_BITS'(n_eff - (PROF_BITS+1)'(1));
    end

    // Counters hold cycles elapsed since the last start;
    // releasing at pri-2 lets LOAD+FIRE land on pri.
    assign pri_thr    = (pri < CNT_W'(2)) ? '0 : pri - CNT_W'(2);
    assign pri_due    = pri_cnt >= pri_thr;
    assign tmo_limit  = {1'b0, len_q} + (LEN_W+1)'(TIMEOUT_MARGIN);
    assign tmo_next   = (LEN_W+1)'(tmo_cnt) + (LEN_W+1)'(1);
    assign tmo_reach  = tmo_next >= tmo_limit;
    assign burst_full = (burst_len != '0) && (chirp_cnt == burst_len);
    assign stop_hit   = stop_req | stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        load      = 1'b0;
        start     = 1'b0;
        advance   = 1'b0;
        set_ovr   = 1'b0;
        set_tmo   = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    clr       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = FIRE;
            end
            FIRE: begin
                if (!dds.dds_busy) begin
                    start     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dds.dds_done) begin
                    if (burst_full || stop_hit) begin
                        state_nxt = FINISH;
                    end else if (pri_due) begin
                        set_ovr   = 1'b1;
                        advance   = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = GAP;
                    end
                end else if (tmo_reach) begin
                    set_tmo   = 1'b1;
                    state_nxt = FINISH;
                end
            end
            GAP: begin
                if (burst_full || stop_hit) begin
                    state_nxt = FINISH;
                end else if (pri_due) begin
                    advance   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_start_q   <= '0;
            f_stop_q    <= '0;
            f_clk_q     <= '0;
            len_q       <= '0;
            pri_cnt     <= '0;
            tmo_cnt     <= '0;
            chirp_cnt   <= '0;
            profile_idx <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            stop_req    <= 1'b0;
        end else begin
            if (clr) begin
                chirp_cnt   <= '0;
                profile_idx <= '0;
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
                stop_req    <= 1'b0;
            end
            if (busy && stop) begin
                stop_req <= 1'b1;
            end
            if (load) begin
                f_start_q <= prof_rd.f_start;
                f_stop_q  <= prof_rd.f_stop;
                len_q     <= prof_rd.chirp_len;
                f_clk_q   <= f_clk;
            end
            if (start) begin
                pri_cnt   <= CNT_W'(1);
                tmo_cnt   <= CNT_W'(1);
                chirp_cnt <= chirp_cnt + CNT_W'(1);
            end else begin
                if (busy && pri_cnt != '1) begin
                    pri_cnt <= pri_cnt + CNT_W'(1);
                end
                if (state == WAIT) begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end
            if (advance) begin
                profile_idx <= (profile_idx >= last_idx) ?
                               '0 : profile_idx + PROF_BITS'(1);
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end
            if (set_tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign busy       = (state == LOAD) || (state == FIRE) ||
                        (state == WAIT) || (state == GAP);
    assign burst_done = (state == FINISH);

    assign dds.dds_start     = start;
    assign dds.dds_f_start   = f_start_q;
    assign dds.dds_f_stop    = f_stop_q;
    assign dds.dds_f_clk     = f_clk_q;
    assign dds.dds_chirp_len = len_q;

endmodule

// File: tb/tb_lfm_chirp_scheduler.sv
// Directed bench for lfm_chirp_scheduler with a
// behavioural DDS model driving busy/done.
module tb_lfm_chirp_scheduler;
    import lfm_pkg::*;

    localparam int NP = 4;
    localparam int PB = 2;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [PB-1:0] cfg_addr = '0;
    logic [31:0]   cfg_f_start = '0;
    logic [31:0]   cfg_f_stop = '0;
    logic [63:0]   cfg_chirp_len = '0;
    logic [31:0]   f_clk = '0;
    logic [PB:0]   n_profiles = 3'd1;
    logic [CW-1:0] pri = '0;
    logic [CW-1:0] burst_len = '0;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic          busy, burst_done, overrun, timeout_err;
    logic [PB-1:0] profile_idx;
    logic [CW-1:0] chirp_cnt;

    lfm_chirp_scheduler_if dds();

    lfm_chirp_scheduler #(
        .NUM_PROFILES   (NP),
        .PROF_BITS      (PB),
        .CNT_W          (CW),
        .TIMEOUT_MARGIN (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_f_start   (cfg_f_start),
        .cfg_f_stop    (cfg_f_stop),
        .cfg_chirp_len (cfg_chirp_len),
        .f_clk         (f_clk),
        .n_profiles    (n_profiles),
        .pri           (pri),
        .burst_len     (burst_len),
        .arm           (arm),
        .stop          (stop),
        .dds           (dds.master),
        .busy          (busy),
        .burst_done    (burst_done),
        .profile_idx   (profile_idx),
        .chirp_cnt     (chirp_cnt),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    int          cyc = 0;
    int          nstart, ndone, bd_n, bd_cyc, tmo_cyc;
    int          start_cyc [32];
    int          done_cyc [32];
    logic [PB-1:0] start_prof [32];
    logic [31:0] start_fs [32];
    int          m_rem = 0;
    bit          suppress = 0;
    logic        prev_tmo = 1'b0;
    logic        s_start, s_bd, s_tmo;
    logic [PB-1:0] s_prof;
    logic [31:0] s_fs;

    // DDS model and event log: done pulses chirp_len
    // cycles after start, busy in between.
    always @(negedge clk) begin
        s_start = dds.dds_start;
        s_bd    = burst_done;
        s_tmo   = timeout_err;
        s_prof  = profile_idx;
        s_fs    = dds.dds_f_start;
        cyc++;
        if (rst) begin
            m_rem        = 0;
            dds.dds_busy = 1'b0;
            dds.dds_done = 1'b0;
            prev_tmo     = 1'b0;
        end else begin
            dds.dds_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                dds.dds_busy = (m_rem != 0);
                if (m_rem == 0 && !suppress) begin
                    dds.dds_done = 1'b1;
                    if (ndone < 32) done_cyc[ndone] = cyc;
                    ndone++;
                end
            end
            if (s_start) begin
                if (nstart < 32) begin
                    start_cyc[nstart]  = cyc;
                    start_prof[nstart] = s_prof;
                    start_fs[nstart]   = s_fs;
                end
                nstart++;
                m_rem = int'(dds.dds_chirp_len[31:0]);
            end
            if (s_bd) begin
                bd_n++;
                bd_cyc = cyc;
            end
            if (s_tmo && !prev_tmo) tmo_cyc = cyc;
            prev_tmo = s_tmo;
        end
    end

    task automatic clear_log();
        nstart  = 0;
        ndone   = 0;
        bd_n    = 0;
        bd_cyc  = -1;
        tmo_cyc = -1;
    endtask

    task automatic write_prof(input int a, input int fs,
                              input int fp, input int len);
        @(posedge clk);
        #1;
        cfg_we        = 1'b1;
        cfg_addr      = a[PB-1:0];
        cfg_f_start   = fs;
        cfg_f_stop    = fp;
        cfg_chirp_len = 64'(len);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_arm();
        @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #1;
            if (bd_n != 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int n, input int lim,
                               output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #1;
            if (nstart >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [255:0] v;
        @(negedge clk);
        #1;
        v = {busy, burst_done, dds.dds_start, overrun,
             timeout_err, profile_idx, chirp_cnt,
             dds.dds_f_start, dds.dds_f_stop,
             dds.dds_f_clk, dds.dds_chirp_len};
        compared++;
        if (v !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got %h want 0", v);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_chirp();
        bit ok;
        write_prof(0, 1000, 10000, 100);
        f_clk      = 32'd1_000_000;
        n_profiles = 3'd1;
        burst_len  = 1;
        pri        = 200;
        clear_log();
        pulse_arm();
        wait_done(400, ok);
        compared++;
        if (!ok || nstart !== 1) begin
            mismatched++;
            $display("FAIL single_starts got %0d want 1 (done=%0d)",
                     nstart, ok);
        end
        compared++;
        if (start_fs[0] !== 32'd1000 ||
            dds.dds_f_stop !== 32'd10000) begin
            mismatched++;
            $display("FAIL single_freq got %0d/%0d want 1000/10000",
                     start_fs[0], dds.dds_f_stop);
        end
        compared++;
        if (dds.dds_f_clk !== 32'd1_000_000 ||
            dds.dds_chirp_len !== 64'd100) begin
            mismatched++;
            $display("FAIL single_clk_len got %0d/%0d want 1000000/100",
                     dds.dds_f_clk, dds.dds_chirp_len);
        end
        compared++;
        if (bd_cyc !== done_cyc[0] + 1) begin
            mismatched++;
            $display("FAIL single_bd_lat got %0d want %0d",
                     bd_cyc, done_cyc[0] + 1);
        end
        compared++;
        if (chirp_cnt !== 1 || overrun !== 0 || timeout_err !== 0) begin
            mismatched++;
            $display("FAIL single_status got cnt=%0d ovr=%b tmo=%b want 1/0/0",
                     chirp_cnt, overrun, timeout_err);
        end
        @(negedge clk);
        #1;
        compared++;
        if (burst_done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_bd_width got bd=%b busy=%b want 0/0",
                     burst_done, busy);
        end
    endtask

    task automatic test_pri_rotation();
        bit ok;
        int exp_prof [5] = '{0, 1, 2, 0, 1};
        write_prof(0, 100, 1100, 50);
        write_prof(1, 200, 1200, 50);
        write_prof(2, 300, 1300, 50);
        n_profiles = 3'd3;
        pri        = 120;
        burst_len  = 5;
        clear_log();
        pulse_arm();
        wait_done(1000, ok);
        compared++;
        if (!ok || nstart !== 5) begin
            mismatched++;
            $display("FAIL pri_starts got %0d want 5", nstart);
        end
        for (int i = 1; i < 5; i++) begin
            compared++;
            if (start_cyc[i] - start_cyc[i-1] !== 120) begin
                mismatched++;
                $display("FAIL pri_spacing[%0d] got %0d want 120",
                         i, start_cyc[i] - start_cyc[i-1]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (start_prof[i] !== exp_prof[i][PB-1:0] ||
                start_fs[i] !== 32'(100 * (exp_prof[i] + 1))) begin
                mismatched++;
                $display("FAIL pri_profile[%0d] got %0d/%0d want %0d/%0d",
                         i, start_prof[i], start_fs[i], exp_prof[i],
                         100 * (exp_prof[i] + 1));
            end
        end
        compared++;
        if (bd_cyc !== done_cyc[4] + 1 || overrun !== 0 ||
            chirp_cnt !== 5) begin
            mismatched++;
            $display("FAIL pri_end got bd=%0d ovr=%b cnt=%0d want %0d/0/5",
                     bd_cyc, overrun, chirp_cnt, done_cyc[4] + 1);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        write_prof(0, 500, 5000, 100);
        n_profiles = 3'd1;
        pri        = 60;
        burst_len  = 3;
        clear_log();
        pulse_arm();
        wait_done(1000, ok);
        compared++;
        if (!ok || nstart !== 3 || ndone !== 3) begin
            mismatched++;
            $display("FAIL ovr_count got %0d/%0d want 3/3", nstart, ndone);
        end
        for (int i = 1; i < 3; i++) begin
            compared++;
            if (start_cyc[i] !== done_cyc[i-1] + 2) begin
                mismatched++;
                $display("FAIL ovr_gap[%0d] got %0d want %0d",
                         i, start_cyc[i], done_cyc[i-1] + 2);
            end
        end
        compared++;
        if (overrun !== 1'b1 || chirp_cnt !== 3) begin
            mismatched++;
            $display("FAIL ovr_flag got ovr=%b cnt=%0d want 1/3",
                     overrun, chirp_cnt);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        write_prof(0, 700, 7000, 20);
        pri       = 100;
        burst_len = 1;
        suppress  = 1;
        clear_log();
        pulse_arm();
        wait_done(200, ok);
        compared++;
        if (!ok || tmo_cyc - start_cyc[0] !== 36) begin
            mismatched++;
            $display("FAIL tmo_latency got %0d want 36",
                     tmo_cyc - start_cyc[0]);
        end
        compared++;
        if (bd_cyc !== tmo_cyc || busy !== 1'b0 ||
            timeout_err !== 1'b1 || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL tmo_end got bd=%0d busy=%b tmo=%b ovr=%b want %0d/0/1/0",
                     bd_cyc, busy, timeout_err, overrun, tmo_cyc);
        end
        suppress = 0;
    endtask

    task automatic test_stop_continuous();
        bit ok;
        write_prof(0, 900, 9000, 30);
        pri       = 50;
        burst_len = 0;
        clear_log();
        pulse_arm();
        wait_starts(4, 400, ok);
        @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_done(200, ok);
        repeat (150) @(negedge clk);
        #1;
        compared++;
        if (!ok || nstart !== 4 || ndone !== 4) begin
            mismatched++;
            $display("FAIL stop_count got %0d/%0d want 4/4", nstart, ndone);
        end
        compared++;
        if (chirp_cnt !== 4 || bd_n !== 1 || bd_cyc !== done_cyc[3] + 1) begin
            mismatched++;
            $display("FAIL stop_end got cnt=%0d bd=%0d@%0d want 4/1@%0d",
                     chirp_cnt, bd_n, bd_cyc, done_cyc[3] + 1);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [255:0] v;
        write_prof(0, 400, 4000, 100);
        pri       = 200;
        burst_len = 1;
        clear_log();
        pulse_arm();
        wait_starts(1, 50, ok);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        v = {busy, burst_done, dds.dds_start, overrun,
             timeout_err, profile_idx, chirp_cnt,
             dds.dds_f_start, dds.dds_f_stop,
             dds.dds_f_clk, dds.dds_chirp_len};
        compared++;
        if (!ok || v !== '0) begin
            mismatched++;
            $display("FAIL async_reset got %h want 0", v);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        compared++;
        if (bd_n !== 0 || nstart !== 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL async_abandon got bd=%0d starts=%0d busy=%b want 0/1/0",
                     bd_n, nstart, busy);
        end
    endtask

    task automatic test_table_write_busy();
        bit ok;
        write_prof(0, 111, 1111, 20);
        write_prof(1, 222, 2222, 20);
        n_profiles = 3'd2;
        pri        = 80;
        burst_len  = 2;
        clear_log();
        pulse_arm();
        wait_starts(1, 50, ok);
        write_prof(1, 333, 3333, 20);
        wait_done(300, ok);
        compared++;
        if (!ok || start_fs[0] !== 32'd111) begin
            mismatched++;
            $display("FAIL wr_chirp0 got %0d want 111", start_fs[0]);
        end
        compared++;
        if (start_fs[1] !== 32'd333 || start_prof[1] !== 2'd1) begin
            mismatched++;
            $display("FAIL wr_chirp1 got %0d/p%0d want 333/p1",
                     start_fs[1], start_prof[1]);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_single_chirp();
        test_pri_rotation();
        test_overrun();
        test_timeout();
        test_stop_continuous();
        test_async_reset();
        test_table_write_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfm_chirp_scheduler.md
Name: lfm_chirp_scheduler

Overview:
- Sequencer in front of the LFM DDS chirp generator.
- Holds a small profile table of chirp settings (f_start, f_stop, chirp_len). Plays a burst of chirps at a fixed pulse repetition interval (PRI), cycling through the table.
- Drives the DDS start/parameter inputs and monitors its done pulse. Reports progress, overrun and timeout.

Parameters:
- NUM_PROFILES, 4, depth of the profile table (power of two, ≥2)
- PROF_BITS, 2, log2(NUM_PROFILES)
- CNT_W, 32, width of the PRI, burst and timeout counters
- TIMEOUT_MARGIN, 16, extra cycles beyond chirp_len allowed before dds_done is declared missing

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  profile table write strobe
- cfg_addr  in  PROF_BITS  profile index to write
- cfg_f_start  in  32  start frequency, Hz
- cfg_f_stop  in  32  stop frequency, Hz
- cfg_chirp_len  in  64  chirp length in samples
- f_clk  in  32  sample clock frequency, Hz; passed through to DDS
- n_profiles  in  PROF_BITS+1  active profiles, 1..NUM_PROFILES; 0 treated as 1
- pri  in  CNT_W  cycles from one dds_start to the next
- burst_len  in  CNT_W  chirps per burst; 0 = continuous
- arm  in  1  one-cycle pulse that starts a burst
- stop  in  1  graceful stop request
- dds_busy  in  1  DDS busy
- dds_done  in  1  DDS one-cycle done pulse
- dds_start  out  1  one-cycle start pulse to DDS
- dds_f_start, dds_f_stop, dds_f_clk  out  32  registered chirp parameters
- dds_chirp_len  out  64  registered chirp length
- busy  out  1  burst in progress
- burst_done  out  1  one-cycle pulse at burst end
- profile_idx  out  PROF_BITS  profile of the current chirp
- chirp_cnt  out  CNT_W  chirps started in this burst
- overrun  out  1  sticky: a chirp finished after its PRI expired
- timeout_err  out  1  sticky: dds_done not seen in time

Behaviour:
- Reset: all outputs 0, table contents 0, state IDLE. Reset mid-burst abandons the burst immediately; dds_start is never glitched.
- Table write:
  - A single-cycle synchronous write; permitted in any state.
  - A chirp uses the table entry as read in LOAD, so a write takes effect from the next LOAD.
- States IDLE → LOAD → FIRE → WAIT → GAP → LOAD …, plus FINISH.
- IDLE:
  - busy=0. On arm, clear chirp_cnt, profile_idx, overrun and timeout_err, then go to LOAD. arm in any other state is ignored.
  - stop in IDLE: no effect.
- LOAD: register table[profile_idx] and f_clk onto dds_* outputs. busy=1. Next state FIRE.
- FIRE:
  - Assert dds_start for exactly one cycle, but only when dds_busy=0; otherwise hold in FIRE until it is.
  - In the dds_start cycle: clear pri_cnt and tmo_cnt, increment chirp_cnt. Next state WAIT.
  - Parameters stay stable from LOAD until the next LOAD.
- pri_cnt increments every cycle from FIRE until the next FIRE. tmo_cnt increments in WAIT.
- WAIT:
  - On dds_done, go to GAP.
  - If tmo_cnt reaches dds_chirp_len+TIMEOUT_MARGIN without dds_done: set timeout_err, go to FINISH.
- GAP, evaluated every cycle:
  - Burst complete (burst_len≠0 and chirp_cnt==burst_len) or stop latched: go to FINISH immediately; no PRI wait.
  - Otherwise, when pri_cnt ≥ pri−2: advance profile_idx (wraps to 0 at n_profiles−1) and go to LOAD. The next dds_start then falls exactly pri cycles after the previous one.
  - If dds_done arrived with pri_cnt already ≥ pri−2: set overrun and proceed at once. Start spacing is then > pri.
- stop:
  - Latched whenever busy=1; the in-flight chirp always completes.
  - stop and dds_done in the same cycle: the chirp counts as complete and the burst ends.
- FINISH: pulse burst_done for one cycle, busy=0, go to IDLE. chirp_cnt and the sticky flags hold until the next arm.
- Degenerate pri: pri<4 behaves as back-to-back chirps (no wait in GAP) with overrun set.
- Width rules:
  - Timeout compare is done at 64 bits.
  - chirp_cnt wraps at 2^CNT_W in continuous mode; overrun and timeout_err are unaffected by the wrap.

Decomposition:
- Shared package lfm_pkg holds:
  - state enum (IDLE, LOAD, FIRE, WAIT, GAP, FINISH);
  - profile record type (f_start, f_stop, chirp_len);
  - widths FREQ_W=32, LEN_W=64.
- One sub-module, lfm_profile_ram: NUM_PROFILES×128-bit register file with one write port and one combinational read port.

Test Plan:
- Single chirp:
  - Stimulus: profile0 = 1 kHz→10 kHz, len 100; f_clk = 1 MHz; n_profiles=1, burst_len=1, pri=200; arm.
  - Required: one dds_start carrying those values; burst_done 1 cycle after dds_done; chirp_cnt=1; no flags.
- PRI spacing and profile rotation:
  - Stimulus: 3 profiles, len 50, pri=120, burst_len=5, DDS model.
  - Required: dds_start edges exactly 120 cycles apart; profile_idx sequence 0,1,2,0,1; burst_done after the 5th done.
- Overrun:
  - Stimulus: len 100, pri=60, burst_len=3.
  - Required: overrun=1; each dds_start 2 cycles after the previous dds_done; 3 chirps complete.
- Timeout:
  - Stimulus: DDS model suppresses done; len 20.
  - Required: timeout_err rises 36 cycles after dds_start; burst_done pulses; busy=0.
- Stop in continuous mode:
  - Stimulus: burst_len=0; stop asserted mid-chirp #4.
  - Required: chirp 4 completes; no 5th dds_start; burst_done; chirp_cnt=4.
- Async reset mid-WAIT and table write while busy:
  - Reset mid-WAIT: all outputs 0 with no clock edge.
  - Table write while busy: a rewrite of profile1 during chirp 0 appears on dds_f_start at chirp 1.
